// File: rtl/imm_gen_pipe.sv
// Multi-lane RISC-V immediate generator with an output FIFO and flush.
// Optional stall counter enabled by defining IMM_GEN_STALL_CNT_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int LANES = 2,
  parameter int DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [LANES*32-1:0]   instr_i,
  input  logic [LANES-1:0]      lane_valid_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [LANES*XLEN-1:0] imm_o,
  output logic [LANES*3-1:0]    imm_type_o,
  output logic [LANES-1:0]      lane_valid_o,
  output logic [31:0]           stall_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUIW  = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_I    = 3'd1,
    T_S    = 3'd2,
    T_B    = 3'd3,
    T_U    = 3'd4,
    T_J    = 3'd5,
    T_Z    = 3'd6
  } imm_type_e;

  logic [LANES*XLEN-1:0] dec_imm;
  logic [LANES*3-1:0]    dec_ty;
  logic [31:0]           ins;
  logic [31:0]           imm32;
  logic [6:0]            op;
  logic [2:0]            f3;
  imm_type_e             ty;
  logic                  zx;

  always_comb begin
    dec_imm = '0;
    dec_ty  = '0;
    ins     = '0;
    imm32   = '0;
    op      = '0;
    f3      = '0;
    ty      = T_NONE;
    zx      = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      ins   = instr_i[32*k +: 32];
      op    = ins[6:0];
      f3    = ins[14:12];
      imm32 = '0;
      ty    = T_NONE;
      zx    = 1'b0;
      if (lane_valid_i[k]) begin
        unique case (1'b1)
          (op == OP_LUI) || (op == OP_AUIPC): begin
            imm32 = {ins[31:12], 12'b0};
            ty    = T_U;
          end
          (op == OP_JAL): begin
            imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                     ins[20], ins[30:21], 1'b0};
            ty    = T_J;
          end
          (op == OP_JALR) || (op == OP_LOAD) ||
          (op == OP_ALUI) || (op == OP_ALUIW): begin
            imm32 = {{20{ins[31]}}, ins[31:20]};
            ty    = T_I;
          end
          (op == OP_BRANCH): begin
            imm32 = {{19{ins[31]}}, ins[31], ins[7],
                     ins[30:25], ins[11:8], 1'b0};
            ty    = T_B;
          end
          (op == OP_STORE): begin
            imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ty    = T_S;
          end
          (op == OP_SYSTEM) && !f3[2]: begin
            imm32 = {{20{ins[31]}}, ins[31:20]};
            ty    = T_I;
          end
          (op == OP_SYSTEM) && f3[2] && (f3[1:0] != 2'b00): begin
            imm32 = {27'b0, ins[19:15]};
            ty    = T_Z;
            zx    = 1'b1;
          end
          default: ;
        endcase
      end
      dec_imm[XLEN*k +: XLEN] = zx ? XLEN'(imm32)
                                   : XLEN'(signed'(imm32));
      dec_ty[3*k +: 3] = ty;
    end
  end

  logic [LANES*XLEN-1:0] imm_mem_q [DEPTH];
  logic [LANES*3-1:0]    ty_mem_q  [DEPTH];
  logic [LANES-1:0]      lv_mem_q  [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  push, pop;

  assign ready_o = (count_q != (AW+1)'(DEPTH));
  assign valid_o = (count_q != '0);
  assign push    = valid_i && ready_o && !flush_i;
  assign pop     = valid_o && ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Payload is reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem_q[i] <= '0;
        ty_mem_q[i]  <= '0;
        lv_mem_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        imm_mem_q[wr_ptr_q] <= dec_imm;
        ty_mem_q[wr_ptr_q]  <= dec_ty;
        lv_mem_q[wr_ptr_q]  <= lane_valid_i;
      end
    end
  end

  assign imm_o        = imm_mem_q[rd_ptr_q];
  assign imm_type_o   = ty_mem_q[rd_ptr_q];
  assign lane_valid_o = lv_mem_q[rd_ptr_q];

`ifdef IMM_GEN_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_q <= '0;
    end else if (valid_i && !ready_o && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=64 main instance plus an
// XLEN=32 instance sharing the same input stimulus.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [127:0] imm;
    logic [5:0]   t;
    logic [1:0]   lv;
  } exp_t;

  logic         clk;
  logic         rstn;
  logic         flush;
  logic         valid_i;
  logic         ready_o;
  logic [63:0]  instr;
  logic [1:0]   lane_valid_i;
  logic         valid_o;
  logic         ready_i;
  logic [127:0] imm_o;
  logic [5:0]   type_o;
  logic [1:0]   lv_o;
  logic [31:0]  stall_o;

  logic         r32;
  logic         v32;
  logic [63:0]  imm32_o;
  logic [5:0]   type32_o;
  logic [1:0]   lv32_o;
  logic [31:0]  stall32_o;

  exp_t q[$];
  int   total;
  int   bad;
  int   exp_stall;

  imm_gen_pipe #(.XLEN(64), .LANES(2), .DEPTH(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr), .lane_valid_i(lane_valid_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .imm_o(imm_o), .imm_type_o(type_o),
    .lane_valid_o(lv_o), .stall_cnt_o(stall_o)
  );

  imm_gen_pipe #(.XLEN(32), .LANES(2), .DEPTH(2)) dut32 (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .valid_i(valid_i), .ready_o(r32),
    .instr_i(instr), .lane_valid_i(lane_valid_i),
    .valid_o(v32), .ready_i(ready_i),
    .imm_o(imm32_o), .imm_type_o(type32_o),
    .lane_valid_o(lv32_o), .stall_cnt_o(stall32_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [63:0] i0, input logic [63:0] i1,
                              input logic [2:0] t0, input logic [2:0] t1,
                              input logic [1:0] lv);
    exp_t e;
    e.imm = {i1, i0};
    e.t   = {t1, t0};
    e.lv  = lv;
    return e;
  endfunction

  // Applies one cycle of inputs; accepted bundles enter the scoreboard.
  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] lv,
                       input logic rdy, input exp_t e);
    valid_i      = v;
    instr        = {b, a};
    lane_valid_i = lv;
    ready_i      = rdy;
    if (v && ready_o && !flush) q.push_back(e);
    if (v && !ready_o) exp_stall++;
  endtask

  function automatic logic [31:0] stall_exp();
`ifdef IMM_GEN_STALL_CNT_EN
    return exp_stall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, '0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_hs got v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
    total++;
    if (imm_o !== '0 || type_o !== '0 || lv_o !== '0) begin
      bad++;
      $display("FAIL reset_data got imm=%h t=%h lv=%b exp 0", imm_o, type_o, lv_o);
    end
    total++;
    if (stall_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_stall got=%0d exp=0", stall_o);
    end
  endtask

  task automatic test_decode();
    logic [31:0] a[5];
    logic [31:0] b[5];
    logic [1:0]  m[5];
    exp_t        e[5];
    exp_t        h;
    int          pops;
    a[0] = 32'hFFF00093; b[0] = 32'h80000037; m[0] = 2'b11;
    e[0] = mk(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 3'd1, 3'd4, 2'b11);
    a[1] = 32'h0080006F; b[1] = 32'h3002D073; m[1] = 2'b11;
    e[1] = mk(64'h8, 64'h5, 3'd5, 3'd6, 2'b11);
    a[2] = 32'hFE112E23; b[2] = 32'h12345037; m[2] = 2'b01;
    e[2] = mk(64'hFFFFFFFFFFFFFFFC, 64'h0, 3'd2, 3'd0, 2'b01);
    a[3] = 32'hFE000EE3; b[3] = 32'h00001017; m[3] = 2'b11;
    e[3] = mk(64'hFFFFFFFFFFFFFFFC, 64'h1000, 3'd3, 3'd4, 2'b11);
    a[4] = 32'h0000007F; b[4] = 32'h0002C073; m[4] = 2'b11;
    e[4] = mk(64'h0, 64'h0, 3'd0, 3'd0, 2'b11);
    pops = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 5) drive(1'b1, a[i], b[i], m[i], 1'b1, e[i]);
      else drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, '0);
      if (i == 1) begin
        total++;
        if (valid_o !== 1'b1) begin
          bad++;
          $display("FAIL decode_latency got v=%b exp=1", valid_o);
        end
      end
      if (valid_o && ready_i) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL decode_extra got imm=%h exp none", imm_o);
        end else begin
          h = q.pop_front();
          pops++;
          if ({imm_o, type_o, lv_o} !== h) begin
            bad++;
            $display("FAIL decode_data got imm=%h t=%h lv=%b exp imm=%h t=%h lv=%b",
                     imm_o, type_o, lv_o, h.imm, h.t, h.lv);
          end
        end
      end
    end
    total++;
    if (pops != 5 || q.size() != 0) begin
      bad++;
      $display("FAIL decode_count got pops=%0d left=%0d exp pops=5 left=0", pops, q.size());
    end
  endtask

  task automatic test_backpressure();
    exp_t e0;
    exp_t e1;
    exp_t h;
    int   pops;
    e0 = mk(64'hFFFFFFFFFFFFF800, 64'h7FF, 3'd1, 3'd1, 2'b11);
    e1 = mk(64'h300, 64'h0, 3'd1, 3'd0, 2'b11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (ready_o !== (i < 2)) begin
        bad++;
        $display("FAIL bp_ready step=%0d got=%b exp=%b", i, ready_o, (i < 2));
      end
      if (i >= 3) begin
        total++;
        if (imm_o !== e0.imm) begin
          bad++;
          $display("FAIL bp_hold got=%h exp=%h", imm_o, e0.imm);
        end
      end
      if (i == 0) drive(1'b1, 32'h8000009B, 32'h7FF13083, 2'b11, 1'b0, e0);
      else if (i == 1) drive(1'b1, 32'h30029073, 32'h0000007F, 2'b11, 1'b0, e1);
      else drive(1'b1, 32'hFFF00093, 32'hFFF00093, 2'b11, 1'b0, e0);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, '0);
    total++;
    if (stall_o !== stall_exp()) begin
      bad++;
      $display("FAIL bp_stall got=%0d exp=%0d", stall_o, stall_exp());
    end
    pops = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, '0);
      if (valid_o && ready_i) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL bp_extra got imm=%h exp none", imm_o);
        end else begin
          h = q.pop_front();
          pops++;
          if ({imm_o, type_o, lv_o} !== h) begin
            bad++;
            $display("FAIL bp_drain got imm=%h t=%h exp imm=%h t=%h",
                     imm_o, type_o, h.imm, h.t);
          end
        end
      end
    end
    total++;
    if (pops != 2 || q.size() != 0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_count got pops=%0d left=%0d v=%b exp 2 0 0", pops, q.size(), valid_o);
    end
  endtask

  task automatic test_flush();
    exp_t e0;
    exp_t e1;
    e0 = mk(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 3'd1, 3'd4, 2'b11);
    e1 = mk(64'h8, 64'h5, 3'd5, 3'd6, 2'b11);
    @(negedge clk);
    drive(1'b1, 32'hFFF00093, 32'h80000037, 2'b11, 1'b0, e0);
    @(negedge clk);
    drive(1'b1, 32'h0080006F, 32'h3002D073, 2'b11, 1'b0, e1);
    @(negedge clk);
    total++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_full got r=%b v=%b exp r=0 v=1", ready_o, valid_o);
    end
    flush = 1'b1;
    drive(1'b1, 32'hFE112E23, 32'hFE112E23, 2'b11, 1'b0, '0);
    @(negedge clk);
    flush = 1'b0;
    q.delete();
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, '0);
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_state got v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
    total++;
    if (stall_o !== stall_exp()) begin
      bad++;
      $display("FAIL flush_stall got=%0d exp=%0d", stall_o, stall_exp());
    end
    repeat (3) @(negedge clk);
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_ghost got v=%b imm=%h exp v=0", valid_o, imm_o);
    end
  endtask

  task automatic test_xlen32();
    @(negedge clk);
    drive(1'b1, 32'hFFF00093, 32'h80000037, 2'b11, 1'b0,
          mk(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 3'd1, 3'd4, 2'b11));
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, '0);
    total++;
    if (v32 !== 1'b1 || imm32_o !== 64'h80000000_FFFFFFFF) begin
      bad++;
      $display("FAIL x32_imm got v=%b imm=%h exp v=1 imm=80000000ffffffff", v32, imm32_o);
    end
    total++;
    if (type32_o !== {3'd4, 3'd1} || lv32_o !== 2'b11) begin
      bad++;
      $display("FAIL x32_type got t=%h lv=%b exp t=21 lv=11", type32_o, lv32_o);
    end
  endtask

  task automatic test_async_reset();
    #2 rstn = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || v32 !== 1'b0) begin
      bad++;
      $display("FAIL areset_hs got v=%b r=%b v32=%b exp 0 1 0", valid_o, ready_o, v32);
    end
    total++;
    if (imm_o !== '0 || imm32_o !== '0 || stall_o !== 32'd0) begin
      bad++;
      $display("FAIL areset_data got imm=%h imm32=%h st=%0d exp 0", imm_o, imm32_o, stall_o);
    end
    q.delete();
    exp_stall = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL areset_after got v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad = 0;
    exp_stall = 0;
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_xlen32();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
